// File: rtl/kpt_stream_out_pkg.sv
// Shared constants and state encoding for the keypoint streamer.
// Field positions describe one packed keypoint-memory entry.
package kpt_stream_out_pkg;

  localparam int MAX_KPT = 2000;
  localparam int ADDR_W  = 11;
  localparam int KPT_W   = 19;

  localparam int ROW_MSB = 18;
  localparam int ROW_LSB = 10;
  localparam int COL_MSB = 9;
  localparam int COL_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ROW,
    COL,
    FIN
  } state_t;

endpackage

// File: rtl/kpt_stream_out.sv
// Streams both keypoint layers as header + row/col word pairs.
// All outputs are registered; a read is issued one state ahead of its word.
module kpt_stream_out #(
  parameter int MAX_KPT = kpt_stream_out_pkg::MAX_KPT,
  parameter int ADDR_W  = kpt_stream_out_pkg::ADDR_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [ADDR_W-1:0]                    kpt_cnt_0,
  input  logic [ADDR_W-1:0]                    kpt_cnt_1,
  output logic                                 mem_rd_en,
  output logic                                 mem_sel,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic [kpt_stream_out_pkg::KPT_W-1:0] mem_rdata,
  output logic                                 out_valid,
  output logic [15:0]                          out_data,
  output logic                                 busy,
  output logic                                 done
);

  import kpt_stream_out_pkg::*;

  function automatic logic [ADDR_W-1:0] clamp(
    input logic [ADDR_W-1:0] c
  );
    return (int'(c) > MAX_KPT) ? ADDR_W'(MAX_KPT) : c;
  endfunction

  state_t            state_q, state_d;
  logic              layer_q, layer_d;
  logic [ADDR_W-1:0] cnt0_q, cnt0_d;
  logic [ADDR_W-1:0] cnt1_q, cnt1_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              more_q, more_d;
  logic [9:0]        col_q, col_d;
  logic              armed_q, armed_d;
  logic              ov_q, ov_d;
  logic [15:0]       od_q, od_d;
  logic              rd_q, rd_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] cur_cnt;
  logic [ADDR_W-1:0] idx_inc;
  logic [ADDR_W-1:0] acc_cnt0;
  logic              end_layer;

  assign cur_cnt  = layer_q ? cnt1_q : cnt0_q;
  assign idx_inc  = idx_q + ADDR_W'(1);
  assign acc_cnt0 = clamp(kpt_cnt_0);

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    idx_d     = idx_q;
    more_d    = more_q;
    col_d     = col_q;
    armed_d   = armed_q | ~start;
    ov_d      = 1'b0;
    od_d      = '0;
    rd_d      = 1'b0;
    sel_d     = sel_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    end_layer = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && armed_q) begin
          state_d = HDR;
          layer_d = 1'b0;
          cnt0_d  = acc_cnt0;
          cnt1_d  = clamp(kpt_cnt_1);
          idx_d   = '0;
          busy_d  = 1'b1;
          armed_d = 1'b0;
          if (acc_cnt0 != '0) begin
            rd_d   = 1'b1;
            sel_d  = 1'b0;
            addr_d = '0;
          end
        end
      end
      HDR: begin
        ov_d = 1'b1;
        od_d = {layer_q, 4'b0, 11'(cur_cnt)};
        if (cur_cnt != '0) state_d = ROW;
        else end_layer = 1'b1;
      end
      ROW: begin
        ov_d    = 1'b1;
        od_d    = {layer_q, 6'b0, mem_rdata[ROW_MSB:ROW_LSB]};
        col_d   = mem_rdata[COL_MSB:COL_LSB];
        state_d = COL;
        more_d  = idx_inc < cur_cnt;
        if (idx_inc < cur_cnt) begin
          idx_d  = idx_inc;
          rd_d   = 1'b1;
          addr_d = idx_inc;
        end
      end
      COL: begin
        ov_d = 1'b1;
        od_d = {layer_q, 5'b0, col_q};
        if (more_q) state_d = ROW;
        else end_layer = 1'b1;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Layer 0 always hands over to layer 1's header, even when empty.
    if (end_layer) begin
      if (!layer_q) begin
        state_d = HDR;
        layer_d = 1'b1;
        idx_d   = '0;
        if (cnt1_q != '0) begin
          rd_d   = 1'b1;
          sel_d  = 1'b1;
          addr_d = '0;
        end
      end else begin
        state_d = FIN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      layer_q <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      idx_q   <= '0;
      more_q  <= 1'b0;
      col_q   <= '0;
      armed_q <= 1'b1;
      ov_q    <= 1'b0;
      od_q    <= '0;
      rd_q    <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      idx_q   <= idx_d;
      more_q  <= more_d;
      col_q   <= col_d;
      armed_q <= armed_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      rd_q    <= rd_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_rd_en = rd_q;
  assign mem_sel   = sel_q;
  assign mem_addr  = addr_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_kpt_stream_out.sv
// Scoreboard bench for kpt_stream_out: a queue model of the stream
// is filled per start and drained by an independent output monitor.
module tb_kpt_stream_out;

  localparam int MAXK = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [10:0] kpt_cnt_0 = '0;
  logic [10:0] kpt_cnt_1 = '0;
  logic        mem_rd_en;
  logic        mem_sel;
  logic [10:0] mem_addr;
  logic [18:0] mem_rdata = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;
  logic        done;

  kpt_stream_out dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kpt_cnt_0 (kpt_cnt_0),
    .kpt_cnt_1 (kpt_cnt_1),
    .mem_rd_en (mem_rd_en),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [18:0] mem0 [2048];
  logic [18:0] mem1 [2048];
  logic [15:0] exp_q [$];

  int checks = 0;
  int passes = 0;
  int words_seen = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int max_rd = -1;
  bit prev_valid = 1'b0;

  // Keypoint memories: registered read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem_sel ? mem1[mem_addr] : mem0[mem_addr];
      if (rst_n) begin
        rd_cnt++;
        if (int'(mem_addr) > max_rd) max_rd = int'(mem_addr);
      end
    end
  end

  task automatic chk(input bit ok, input string name,
                     input int act, input int req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)",
                  name, act, act, req, req);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "word_unexpected", int'(out_data), -1);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk(out_data === e, "word", int'(out_data), int'(e));
        end
      end else if (prev_valid) begin
        chk(exp_q.size() == 0, "stream_gap", exp_q.size(), 0);
        chk(out_data == 16'h0, "data_idle_zero", int'(out_data), 0);
      end
      if (done) begin
        done_cnt++;
        chk(!out_valid && prev_valid && !busy, "done_timing",
            {out_valid, prev_valid, busy}, 3'b010);
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  function automatic int clampn(input int n);
    return (n > MAXK) ? MAXK : n;
  endfunction

  task automatic push_expected(input int n0, input int n1);
    for (int l = 0; l < 2; l++) begin
      int n;
      n = clampn(l == 0 ? n0 : n1);
      exp_q.push_back(16'((l << 15) + n));
      for (int i = 0; i < n; i++) begin
        int e;
        e = int'(l == 0 ? mem0[i] : mem1[i]);
        exp_q.push_back(16'((l << 15) + (e / 1024)));
        exp_q.push_back(16'((l << 15) + (e % 1024)));
      end
    end
  endtask

  task automatic run_stream(input int n0, input int n1, input int hold);
    int w0, d0, c, n0c, n1c, total;
    bit got;
    n0c = clampn(n0);
    n1c = clampn(n1);
    total = 2 + 2 * (n0c + n1c);
    w0 = words_seen;
    d0 = done_cnt;
    rd_cnt = 0;
    max_rd = -1;
    push_expected(n0, n1);
    kpt_cnt_0 = 11'(n0);
    kpt_cnt_1 = 11'(n1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk(busy && !out_valid, "busy_after_accept", {busy, out_valid}, 2'b10);
    kpt_cnt_0 = 11'($urandom);
    kpt_cnt_1 = 11'($urandom);
    if (hold <= 1) start = 1'b0;
    @(negedge clk);
    chk(out_valid && out_data == 16'(n0c), "header_latency",
        int'(out_data), n0c);
    c = 2;
    got = 1'b0;
    while (!got && c < 20000) begin
      @(negedge clk);
      c++;
      if (c >= hold) start = 1'b0;
      if (done) got = 1'b1;
    end
    chk(got, "done_timeout", c, 20000);
    repeat (25) begin
      @(negedge clk);
      c++;
      if (c >= hold) start = 1'b0;
    end
    start = 1'b0;
    chk(done_cnt - d0 == 1, "done_count", done_cnt - d0, 1);
    chk(words_seen - w0 == total, "word_count", words_seen - w0, total);
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    chk(rd_cnt == n0c + n1c, "read_count", rd_cnt, n0c + n1c);
    chk(max_rd == ((n0c > n1c ? n0c : n1c) - 1), "max_read_addr",
        max_rd, (n0c > n1c ? n0c : n1c) - 1);
    exp_q.delete();
  endtask

  task automatic reset_mid_stream();
    int d0, c;
    bit seen;
    d0 = done_cnt;
    push_expected(3, 3);
    kpt_cnt_0 = 11'd3;
    kpt_cnt_1 = 11'd3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      if (out_valid && out_data == 16'h8003) seen = 1'b1;
    end
    chk(seen, "layer1_header_seen", c, 200);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk(!out_valid && out_data == 16'h0, "reset_out_clear",
        int'(out_data), 0);
    chk(!busy && !mem_rd_en && !done, "reset_ctrl_clear",
        {busy, mem_rd_en, done}, 0);
    repeat (2) @(negedge clk);
    chk(done_cnt == d0, "no_done_on_abort", done_cnt - d0, 0);
    rst_n = 1'b1;
    run_stream(3, 3, 1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem0[i] = 19'($urandom);
      mem1[i] = 19'($urandom);
    end
    #1 rst_n = 1'b0;
    #1;
    chk(!out_valid && out_data == 16'h0, "rst_out", int'(out_data), 0);
    chk(!mem_rd_en && !mem_sel && mem_addr == 11'd0, "rst_mem",
        {mem_rd_en, mem_sel, mem_addr}, 0);
    chk(!busy && !done, "rst_busy_done", {busy, done}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    mem0[0] = {9'd5, 10'd7};
    mem0[1] = {9'd100, 10'd639};
    run_stream(2, 0, 1);

    mem1[0] = {9'd479, 10'd0};
    run_stream(0, 1, 1);

    run_stream(0, 0, 1);

    run_stream(2047, 0, 1);
    chk(max_rd == 1999, "clamp_last_addr", max_rd, 1999);

    run_stream(1, 2047, 1);

    run_stream(1, 1, 20);

    repeat (6) begin
      run_stream(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                 int'($urandom_range(1, 3)));
    end

    reset_mid_stream();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
